// File: rtl/nonrestoring_divider.sv
// Sequential unsigned radix-2 non-restoring divider, one quotient bit per clock.
// start/busy/done handshake; results and div_by_zero held until overwritten.
module nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one non-restoring iteration per cycle, WIDTH cycles
  // FIX   | final remainder correction, load results
  // DONE  | done pulse; a new start is accepted here as in IDLE
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   p_q, p_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] d_q, d_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
  logic             div_by_zero_nxt, busy_nxt, done_nxt;
  logic [WIDTH:0]   shift, d_ext, p_step, p_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign shift  = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign d_ext  = {1'b0, d_q};
  // sign of the partial remainder picks subtract (>=0) or add-back (<0)
  assign p_step = p_q[WIDTH] ? (shift + d_ext) : (shift - d_ext);
  assign p_fix  = p_q[WIDTH] ? (p_q + d_ext) : p_q;

  always_comb begin
    state_nxt       = state;
    p_nxt           = p_q;
    a_nxt           = a_q;
    d_nxt           = d_q;
    cnt_nxt         = cnt_q;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    div_by_zero_nxt = div_by_zero;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          if (divisor != '0) begin
            p_nxt           = '0;
            a_nxt           = dividend;
            d_nxt           = divisor;
            cnt_nxt         = CW'(WIDTH);
            div_by_zero_nxt = 1'b0;
            state_nxt       = RUN;
          end else begin
            quotient_nxt    = '1;
            remainder_nxt   = dividend;
            div_by_zero_nxt = 1'b1;
            state_nxt       = DONE;
          end
        end
      end
      RUN: begin
        p_nxt   = p_step;
        a_nxt   = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_nxt = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_nxt = FIX;
      end
      FIX: begin
        p_nxt         = p_fix;
        quotient_nxt  = a_q;
        remainder_nxt = p_fix[WIDTH-1:0];
        state_nxt     = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == RUN) || (state_nxt == FIX);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      a_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      p_q         <= p_nxt;
      a_q         <= a_nxt;
      d_q         <= d_nxt;
      cnt_q       <= cnt_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= div_by_zero_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider (WIDTH=8): driver pushes expected
// results, a negedge monitor pops and checks results, latency and busy length.
module tb_nonrestoring_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int z;
    int lat;
    int bcyc;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // expected latency counts edges from the accepting edge to the done cycle
  always @(negedge clk) begin
    exp_t e;
    int   acc;
    if (!rst_n) begin
      acc_q.delete();
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e   = exp_q.pop_front();
          acc = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
          check("quotient", int'(quotient), e.q);
          check("remainder", int'(remainder), e.r);
          check("div_by_zero", int'(div_by_zero), e.z);
          check("latency", cyc - acc, e.lat);
          check("busy_cycles", busy_cnt, e.bcyc);
        end
        busy_cnt = 0;
      end
      if (start && !busy) acc_q.push_back(cyc + 1);
    end
  end

  task automatic push_exp(input int q, input int r, input int z);
    exp_t e;
    e.q = q; e.r = r; e.z = z;
    e.lat  = z ? 0 : W + 1;
    e.bcyc = z ? 0 : W + 1;
    exp_q.push_back(e);
  endtask

  // called just after a posedge; returns just after the accepting posedge
  task automatic issue(input int dd, input int dv, input int q, input int r, input int z,
                       input bit expect_result);
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("wait_not_busy", 1, 0);
    dividend = W'(dd);
    divisor  = W'(dv);
    start    = 1'b1;
    if (expect_result) push_exp(q, r, z);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  int vdd[10] = '{100, 255,   5, 255, 0, 200,  17, 128, 254, 1};
  int vdv[10] = '{  7,   1,   9, 255, 3,   0,   5,  16, 255, 0};
  int vq[10]  = '{ 14, 255,   0,   1, 0, 255,   3,   8,   0, 255};
  int vr[10]  = '{  2,   0,   5,   0, 0, 200,   2,   0, 254, 1};
  int vz[10]  = '{  0,   0,   0,   0, 0,   1,   0,   0,   0, 1};

  initial begin
    int n;
    int a, b;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) issue(vdd[i], vdv[i], vq[i], vr[i], vz[i], 1'b1);

    // start held high; operands change mid-run and are taken in the DONE cycle
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    dividend = 8'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    push_exp(16, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    dividend = 8'd9;
    divisor  = 8'd9;
    push_exp(1, 0, 0);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_first_done_seen", int'(done), 1);
    @(posedge clk); #1;
    start = 1'b0;

    // reset mid-division aborts without a done pulse
    issue(100, 7, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_div_by_zero", int'(div_by_zero), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("abort_idle_busy", int'(busy), 0);
    issue(100, 7, 14, 2, 0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 1));
      issue(a, b, a / b, a % b, 0, 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("pending_results", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
